u_dly_coarse_prog: RTL and testbench
====================================

Name: u_dly_coarse_prog

Overview:
Synthesizable, clocked successor to the behavioural coarse delay cell. It provides NUM_CH independent programmable delay channels. Each channel delays its input by a whole number of i_clk cycles, chosen from 2^SEL_W taps. Delay-select changes are accepted through a valid/ready handshake and applied one tap per STEP_CYC cycles, so that lock loops in the DLL/DFF path see monotonic, glitch-bounded delay updates.

Parameters:
NUM_CH, 4, number of independent delay channels
DW, 1, data width per channel
SEL_W, 3, select width; tap count = 2^SEL_W, max delay index = 2^SEL_W-1
STEP_CYC, 4, clock cycles between successive one-tap select steps (>=1)

Ports:
i_clk  input  1  single clock
i_rstn  input  1  asynchronous active-low reset
i_in  input  NUM_CH*DW  channel data in; channel c at [c*DW +: DW]
i_sel  input  NUM_CH*SEL_W  target delay index per channel; channel c at [c*SEL_W +: SEL_W]
i_sel_vld  input  1  i_sel is valid
o_sel_rdy  output  1  block accepts a new target (high only in IDLE)
o_busy  output  1  stepping toward target in progress (= ~o_sel_rdy)
o_sel_cur  output  NUM_CH*SEL_W  currently applied delay index per channel
o_out  output  NUM_CH*DW  delayed data out

Behaviour:
- Reset (i_rstn low, async):
  - all tap registers, o_out and o_sel_cur = 0
  - target registers = 0; step counter = 0
  - FSM = IDLE, so o_sel_rdy = 1, o_busy = 0
- Datapath, per channel:
  - shift register of 2^SEL_W-1 stages clocked every cycle; tap 0 = i_in
  - o_out is a register loaded from the tap selected by o_sel_cur
  - latency = o_sel_cur + 1 cycles: o_out(t) = i_in(t-1-sel_cur)
  - sel 0 gives latency 1; max sel gives latency 2^SEL_W
- FSM states: IDLE, STEP.
- IDLE:
  - o_sel_rdy = 1
  - on i_sel_vld && o_sel_rdy at a clock edge: latch i_sel into target registers, clear counter, go to STEP
  - i_sel_vld while not ready is ignored (no queueing)
- STEP:
  - if o_sel_cur == target for all channels: go to IDLE on this edge; counter is don't-care
  - else if counter == STEP_CYC-1: every mismatched channel moves exactly one tap toward its target (+1 or -1); matched channels hold; counter <= 0
  - else counter <= counter + 1
- Step timing: the first step occurs STEP_CYC edges after accept. Channels step in parallel; direction is per channel.
- Target equal to current: one cycle in STEP, then IDLE; o_sel_rdy is low for exactly 1 cycle.
- Arithmetic: o_sel_cur never wraps; steps are bounded by the target, which is always inside 0..2^SEL_W-1. The counter width is clog2(STEP_CYC), minimum 1.
- The data path keeps shifting during stepping. Each index change alters latency by exactly 1 cycle: one sample is dropped (increase) or duplicated (decrease).
- Reset mid-step: immediate return to reset state, with o_sel_cur = 0 regardless of target.
- The delay select is applied to the output mux in the same edge it updates. No combinational path from i_in to o_out.

Test Plan:
- Reset release, drive a single-cycle pulse on ch0 i_in -> o_out[ch0] pulses exactly 1 cycle later; o_sel_rdy=1, o_sel_cur=0, o_busy=0.
- STEP_CYC=4, accept i_sel ch0=5 from 0 -> o_sel_cur ch0 = 1,2,3,4,5 at edges 4,8,12,16,20 after accept; o_sel_rdy returns high after edge 21; a pulse then emerges 6 cycles after injection.
- Mixed directions: cur {7,0,3,3}, target {2,4,3,3} -> ch0 decrements and ch1 increments on the same edges, ch2/ch3 hold. Busy lasts until ch0 reaches 2 (5 steps, 20 edges, +1).
- Target == current -> o_sel_rdy low for exactly 1 cycle; o_sel_cur and o_out stream unchanged.
- i_sel_vld pulsed with a new target while busy -> ignored; the original target is reached and o_sel_cur never shows the ignored value.
- Assert i_rstn low asynchronously mid-step (between clock edges) -> o_out and o_sel_cur are 0 immediately and o_sel_rdy=1. After release, latency is 1 cycle.

Source files
------------

// File: rtl/u_dly_coarse_prog.sv
// u_dly_coarse_prog: NUM_CH independent programmable coarse delay channels.
// Each channel delays its input by (o_sel_cur + 1) clock cycles. A new target
// select vector is accepted by a valid/ready handshake. The applied select
// then walks toward it one tap per STEP_CYC cycles, so the delay changes
// monotonically and in bounded steps.
//
// Ports:
//   i_clk       clock
//   i_rstn      asynchronous active-low reset
//   i_in        channel data in, channel c at [c*DW +: DW]
//   i_sel       target delay index, channel c at [c*SEL_W +: SEL_W]
//   i_sel_vld   i_sel is valid
//   o_sel_rdy   a new target is accepted (idle)
//   o_busy      stepping toward target (= ~o_sel_rdy)
//   o_sel_cur   currently applied delay index per channel
//   o_out       delayed data out (registered)
module u_dly_coarse_prog #(
  parameter int unsigned NUM_CH   = 4,
  parameter int unsigned DW       = 1,
  parameter int unsigned SEL_W    = 3,
  parameter int unsigned STEP_CYC = 4
) (
  input  logic                    i_clk,
  input  logic                    i_rstn,
  input  logic [NUM_CH*DW-1:0]    i_in,
  input  logic [NUM_CH*SEL_W-1:0] i_sel,
  input  logic                    i_sel_vld,
  output logic                    o_sel_rdy,
  output logic                    o_busy,
  output logic [NUM_CH*SEL_W-1:0] o_sel_cur,
  output logic [NUM_CH*DW-1:0]    o_out
);

  localparam int unsigned Taps = 2 ** SEL_W;
  localparam int unsigned CntW = (STEP_CYC > 1) ? $clog2(STEP_CYC) : 1;
  localparam logic [CntW-1:0] CntMax = CntW'(STEP_CYC - 1);

  typedef enum logic [0:0] {StIdle, StStep} state_e;

  state_e            state_q, state_d;
  logic [CntW-1:0]   cnt_q, cnt_d;
  logic              rdy_q, rdy_d;
  logic [SEL_W-1:0]  cur_q [NUM_CH];
  logic [SEL_W-1:0]  cur_d [NUM_CH];
  logic [SEL_W-1:0]  tgt_q [NUM_CH];
  logic [SEL_W-1:0]  tgt_d [NUM_CH];
  logic [DW-1:0]     dly_q [NUM_CH][Taps-1];
  logic [DW-1:0]     out_q [NUM_CH];
  logic [DW-1:0]     out_d [NUM_CH];
  logic              all_match;

  // Next-state for the select walker.
  always_comb begin
    all_match = 1'b1;
    for (int c = 0; c < NUM_CH; c++) begin
      if (cur_q[c] != tgt_q[c]) all_match = 1'b0;
    end

    state_d = state_q;
    cnt_d   = cnt_q;
    cur_d   = cur_q;
    tgt_d   = tgt_q;

    unique case (state_q)
      StIdle: begin
        if (i_sel_vld) begin
          for (int c = 0; c < NUM_CH; c++) tgt_d[c] = i_sel[c*SEL_W +: SEL_W];
          cnt_d   = '0;
          state_d = StStep;
        end
      end
      StStep: begin
        if (all_match) begin
          state_d = StIdle;
        end else if (cnt_q == CntMax) begin
          cnt_d = '0;
          // Each mismatched channel moves one tap toward its own target.
          for (int c = 0; c < NUM_CH; c++) begin
            if (cur_q[c] < tgt_q[c]) begin
              cur_d[c] = cur_q[c] + SEL_W'(1);
            end else if (cur_q[c] > tgt_q[c]) begin
              cur_d[c] = cur_q[c] - SEL_W'(1);
            end
          end
        end else begin
          cnt_d = cnt_q + CntW'(1);
        end
      end
      default: state_d = StIdle;
    endcase

    rdy_d = (state_d == StIdle);
  end

  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) begin
      state_q <= StIdle;
      cnt_q   <= '0;
      rdy_q   <= 1'b1;
      for (int c = 0; c < NUM_CH; c++) begin
        cur_q[c] <= '0;
        tgt_q[c] <= '0;
      end
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      rdy_q   <= rdy_d;
      cur_q   <= cur_d;
      tgt_q   <= tgt_d;
    end
  end

  // Output mux uses the select being written this edge, so o_out and
  // o_sel_cur always describe the same latency.
  always_comb begin
    for (int c = 0; c < NUM_CH; c++) begin
      out_d[c] = i_in[c*DW +: DW];
      for (int s = 1; s < Taps; s++) begin
        if (cur_d[c] == SEL_W'(s)) out_d[c] = dly_q[c][s-1];
      end
    end
  end

  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) begin
      for (int c = 0; c < NUM_CH; c++) begin
        out_q[c] <= '0;
        for (int s = 0; s < Taps - 1; s++) dly_q[c][s] <= '0;
      end
    end else begin
      for (int c = 0; c < NUM_CH; c++) begin
        out_q[c]    <= out_d[c];
        dly_q[c][0] <= i_in[c*DW +: DW];
        for (int s = 1; s < Taps - 1; s++) dly_q[c][s] <= dly_q[c][s-1];
      end
    end
  end

  assign o_sel_rdy = rdy_q;
  assign o_busy    = ~rdy_q;

  for (genvar g = 0; g < NUM_CH; g++) begin : g_pack
    assign o_sel_cur[g*SEL_W +: SEL_W] = cur_q[g];
    assign o_out[g*DW +: DW]           = out_q[g];
  end

endmodule

// File: tb/tb_u_dly_coarse_prog.sv
// Bench for u_dly_coarse_prog: directed scenarios with literal expectations,
// then randomized traffic checked every cycle against a schedule-based model.
module tb_u_dly_coarse_prog;

  localparam int NUM_CH   = 4;
  localparam int DW       = 1;
  localparam int SEL_W    = 3;
  localparam int STEP_CYC = 4;

  logic                    i_clk = 1'b0;
  logic                    i_rstn = 1'b0;
  logic [NUM_CH*DW-1:0]    i_in = '0;
  logic [NUM_CH*SEL_W-1:0] i_sel = '0;
  logic                    i_sel_vld = 1'b0;
  logic                    o_sel_rdy;
  logic                    o_busy;
  logic [NUM_CH*SEL_W-1:0] o_sel_cur;
  logic [NUM_CH*DW-1:0]    o_out;

  u_dly_coarse_prog #(
    .NUM_CH  (NUM_CH),
    .DW      (DW),
    .SEL_W   (SEL_W),
    .STEP_CYC(STEP_CYC)
  ) dut (
    .i_clk    (i_clk),
    .i_rstn   (i_rstn),
    .i_in     (i_in),
    .i_sel    (i_sel),
    .i_sel_vld(i_sel_vld),
    .o_sel_rdy(o_sel_rdy),
    .o_busy   (o_busy),
    .o_sel_cur(o_sel_cur),
    .o_out    (o_out)
  );

  always #5 i_clk = ~i_clk;

  int n_chk  = 0;
  int n_pass = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
  endtask

  // Model: an accepted request at edge a moves each channel min(k, |dist|)
  // taps toward target, k = (n - a) / STEP_CYC; ready returns at edge
  // a + STEP_CYC*maxdist + 1. Output is the input sampled cur edges ago.
  logic [NUM_CH*DW-1:0]    hist [256];
  int                      m_n;
  bit                      m_idle;
  int                      m_acc, m_done;
  int                      m_cur [NUM_CH];
  int                      m_start [NUM_CH];
  int                      m_tgt [NUM_CH];
  logic [NUM_CH*DW-1:0]    exp_out;
  logic [NUM_CH*SEL_W-1:0] exp_cur;
  bit                      cmp_en = 1'b0;

  task automatic model_reset();
    m_n    = 0;
    m_idle = 1'b1;
    for (int c = 0; c < NUM_CH; c++) begin
      m_cur[c] = 0;
      m_start[c] = 0;
      m_tgt[c] = 0;
    end
    exp_out = '0;
    exp_cur = '0;
  endtask

  always @(posedge i_clk) begin : model_p
    int k, d, ad, dmax, idx;
    if (i_rstn) begin
      hist[m_n % 256] = i_in;
      if (m_idle) begin
        if (i_sel_vld) begin
          m_acc = m_n;
          dmax  = 0;
          for (int c = 0; c < NUM_CH; c++) begin
            m_start[c] = m_cur[c];
            m_tgt[c]   = int'(i_sel[c*SEL_W +: SEL_W]);
            ad = (m_tgt[c] > m_cur[c]) ? m_tgt[c] - m_cur[c] : m_cur[c] - m_tgt[c];
            if (ad > dmax) dmax = ad;
          end
          m_done = m_n + STEP_CYC * dmax + 1;
          m_idle = 1'b0;
        end
      end else begin
        k = (m_n - m_acc) / STEP_CYC;
        for (int c = 0; c < NUM_CH; c++) begin
          d  = m_tgt[c] - m_start[c];
          ad = (d < 0) ? -d : d;
          if (k < ad) ad = k;
          m_cur[c] = (d < 0) ? m_start[c] - ad : m_start[c] + ad;
        end
        if (m_n == m_done) m_idle = 1'b1;
      end
      for (int c = 0; c < NUM_CH; c++) begin
        idx = m_n - m_cur[c];
        exp_out[c*DW +: DW]       = (idx >= 0) ? hist[idx % 256][c*DW +: DW] : '0;
        exp_cur[c*SEL_W +: SEL_W] = m_cur[c][SEL_W-1:0];
      end
      m_n++;
    end
  end

  always @(negedge i_clk) begin
    if (cmp_en) begin
      chk("o_out", 32'(o_out), 32'(exp_out));
      chk("o_sel_cur", 32'(o_sel_cur), 32'(exp_cur));
      chk("o_sel_rdy", 32'(o_sel_rdy), 32'(m_idle));
      chk("o_busy", 32'(o_busy), 32'(!m_idle));
    end
  end

  task automatic accept(input logic [NUM_CH*SEL_W-1:0] s);
    @(negedge i_clk);
    i_sel     = s;
    i_sel_vld = 1'b1;
    @(negedge i_clk);
    i_sel_vld = 1'b0;
  endtask

  task automatic wait_idle(input int budget);
    int j = 0;
    while (!o_sel_rdy && j < budget) begin
      @(negedge i_clk);
      j++;
    end
    chk("wait_idle", 32'(o_sel_rdy), 32'd1);
  endtask

  // Inject a one-cycle pulse on channel ch and measure cycles until it shows.
  task automatic pulse_latency(input int ch, input int exp_lat, input string name);
    int j = 1;
    @(negedge i_clk);
    i_in[ch*DW] = 1'b1;
    @(negedge i_clk);
    i_in[ch*DW] = 1'b0;
    while (!o_out[ch*DW] && j <= 20) begin
      @(negedge i_clk);
      j++;
    end
    chk(name, 32'(j), 32'(exp_lat));
    @(negedge i_clk);
    chk({name, "_width"}, 32'(o_out[ch*DW]), 32'd0);
  endtask

  // Count cycles with ready low over k = 0..last after accept; optionally
  // check the applied select at edge probe_k.
  task automatic busy_span(input int last, input int probe_k,
                           input logic [NUM_CH*SEL_W-1:0] probe_val, output int busy);
    busy = 0;
    for (int k = 0; k <= last; k++) begin
      if (k == probe_k) chk("probe_cur", 32'(o_sel_cur), 32'(probe_val));
      if (!o_sel_rdy) busy++;
      if (k < last) @(negedge i_clk);
    end
  endtask

  initial begin
    int busy;
    model_reset();
    cmp_en = 1'b1;
    repeat (3) @(negedge i_clk);
    i_rstn = 1'b1;

    chk("rst_sel_cur", 32'(o_sel_cur), 32'd0);
    chk("rst_rdy", 32'(o_sel_rdy), 32'd1);
    chk("rst_busy", 32'(o_busy), 32'd0);
    chk("rst_out", 32'(o_out), 32'd0);
    pulse_latency(0, 1, "lat_sel0");

    // ch0 0 -> 5: one step every 4 edges, ready back after edge 21.
    accept({3'd0, 3'd0, 3'd0, 3'd5});
    busy = 0;
    for (int k = 0; k <= 21; k++) begin
      if (k > 0 && k % 4 == 0 && k <= 20) chk("step_cur", 32'(o_sel_cur[2:0]), 32'(k / 4));
      if (k == 20) chk("rdy_at20", 32'(o_sel_rdy), 32'd0);
      if (!o_sel_rdy) busy++;
      if (k < 21) @(negedge i_clk);
    end
    chk("busy_len_5", 32'(busy), 32'd21);
    chk("rdy_at21", 32'(o_sel_rdy), 32'd1);
    pulse_latency(0, 6, "lat_sel5");

    // Mixed directions: {7,0,3,3} -> {2,4,3,3}.
    accept({3'd3, 3'd3, 3'd0, 3'd7});
    wait_idle(80);
    chk("mixed_start", 32'(o_sel_cur), 32'(12'({3'd3, 3'd3, 3'd0, 3'd7})));
    accept({3'd3, 3'd3, 3'd4, 3'd2});
    busy_span(21, 4, {3'd3, 3'd3, 3'd1, 3'd6}, busy);
    chk("busy_len_mixed", 32'(busy), 32'd21);
    chk("mixed_end", 32'(o_sel_cur), 32'(12'({3'd3, 3'd3, 3'd4, 3'd2})));

    // Target equal to current: ready low for a single cycle.
    accept({3'd3, 3'd3, 3'd4, 3'd2});
    busy_span(3, 2, {3'd3, 3'd3, 3'd4, 3'd2}, busy);
    chk("busy_len_same", 32'(busy), 32'd1);
    pulse_latency(0, 3, "lat_sel2");

    // Request while busy is ignored.
    accept({3'd0, 3'd0, 3'd0, 3'd5});
    repeat (2) @(negedge i_clk);
    i_sel     = {3'd7, 3'd7, 3'd7, 3'd7};
    i_sel_vld = 1'b1;
    @(negedge i_clk);
    i_sel_vld = 1'b0;
    wait_idle(80);
    chk("ignored_cur", 32'(o_sel_cur), 32'(12'({3'd0, 3'd0, 3'd0, 3'd5})));
    repeat (2) @(negedge i_clk);
    chk("ignored_rdy", 32'(o_sel_rdy), 32'd1);

    // Asynchronous reset in the middle of a walk.
    i_in = '1;
    accept({3'd7, 3'd7, 3'd7, 3'd7});
    repeat (10) @(negedge i_clk);
    chk("pre_rst_out", 32'(o_out), 32'hf);
    #2;
    i_rstn = 1'b0;
    i_in   = '0;
    model_reset();
    #1;
    chk("async_out", 32'(o_out), 32'd0);
    chk("async_cur", 32'(o_sel_cur), 32'd0);
    chk("async_rdy", 32'(o_sel_rdy), 32'd1);
    chk("async_busy", 32'(o_busy), 32'd0);
    @(negedge i_clk);
    i_rstn = 1'b1;
    pulse_latency(0, 1, "lat_after_rst");

    // Randomized traffic checked by the model every cycle.
    for (int i = 0; i < 3000; i++) begin
      @(negedge i_clk);
      i_in      = NUM_CH'($urandom);
      i_sel     = 12'($urandom);
      i_sel_vld = ($urandom_range(0, 5) == 0);
    end
    @(negedge i_clk);
    i_sel_vld = 1'b0;
    wait_idle(80);
    repeat (2) @(negedge i_clk);
    cmp_en = 1'b0;
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
